// File: rtl/nvram_upload.sv
// Upload-side ioctl responder: pauses the game CPU and streams game work RAM
// bytes to the HPS on request, returning 8'hFF beyond the valid area.
module nvram_upload #(
  parameter logic [7:0] INDEX    = 8'd4,
  parameter int         ADDR_W   = 10,
  parameter int         SIZE     = 1024,
  parameter int         READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              busy,
  output logic              ram_pause,
  input  logic              ram_ack,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data
);

  typedef enum logic [2:0] {IDLE, REQ, FETCH, READY, RELEASE} state_t;

  localparam logic [24:0] SIZE_A = 25'(SIZE);
  localparam logic [1:0]  LAT    = 2'(READ_LAT);

  state_t            state, state_next;
  logic              active, active_q;
  logic [24:0]       addr_q, addr_next;
  logic [1:0]        cnt, cnt_next;
  logic [7:0]        din_next;
  logic              busy_next, pause_next, rd_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic              fetch_go;
  logic [24:0]       fetch_addr;

  assign active = ioctl_upload && (ioctl_index == INDEX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      active_q  <= 1'b0;
      addr_q    <= '0;
      cnt       <= '0;
      ioctl_din <= 8'h00;
      busy      <= 1'b0;
      ram_pause <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
    end else begin
      state     <= state_next;
      active_q  <= active;
      addr_q    <= addr_next;
      cnt       <= cnt_next;
      ioctl_din <= din_next;
      busy      <= busy_next;
      ram_pause <= pause_next;
      ram_rd    <= rd_next;
      ram_addr  <= ram_addr_next;
    end
  end

  // Every output is computed here as a next value and registered above.
  always_comb begin
    state_next    = state;
    addr_next     = addr_q;
    cnt_next      = cnt;
    din_next      = ioctl_din;
    busy_next     = busy;
    pause_next    = ram_pause;
    rd_next       = 1'b0;
    ram_addr_next = ram_addr;
    fetch_go      = 1'b0;
    fetch_addr    = addr_q;

    unique case (state)
      IDLE: begin
        din_next      = 8'h00;
        busy_next     = 1'b0;
        pause_next    = 1'b0;
        ram_addr_next = '0;
        if (active && !active_q) begin
          state_next = REQ;
          pause_next = 1'b1;
        end
      end
      REQ: begin
        if (!active) begin
          state_next = RELEASE;
          pause_next = 1'b0;
        end else if (ram_ack) begin
          fetch_go   = 1'b1;
          fetch_addr = '0;
          busy_next  = 1'b1;
        end
      end
      FETCH, READY: begin
        if (!active) begin
          state_next = RELEASE;
          pause_next = 1'b0;
          busy_next  = 1'b0;
        end else if (!ram_ack) begin
          // Losing the RAM port mid-upload: never hand back possibly bad data.
          state_next = RELEASE;
          pause_next = 1'b0;
          busy_next  = 1'b0;
          din_next   = 8'hFF;
        end else if (ioctl_rd) begin
          fetch_go   = 1'b1;
          fetch_addr = ioctl_addr;
        end else if (state == FETCH) begin
          if (cnt == LAT) begin
            state_next = READY;
            din_next   = (addr_q >= SIZE_A) ? 8'hFF : ram_data;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end
      end
      RELEASE: begin
        state_next = IDLE;
        pause_next = 1'b0;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    // A new request always restarts the latency count, discarding older reads.
    if (fetch_go) begin
      state_next    = FETCH;
      addr_next     = fetch_addr;
      cnt_next      = '0;
      rd_next       = (fetch_addr < SIZE_A);
      ram_addr_next = fetch_addr[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_nvram_upload.sv
// Randomised scoreboard bench for nvram_upload: stimulus pushes expected bytes
// with their due cycle, a monitor pops and compares them against ioctl_din.
module tb_nvram_upload;

  localparam int RL = 2;
  localparam int SZ = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd4;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        busy;
  logic        ram_pause;
  logic        ram_ack = 1'b0;
  logic        ram_rd;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_count = 0;
  int exp_rd = 0;

  logic [7:0] mem [0:SZ-1];
  logic [7:0] pipe [RL];

  typedef struct {
    logic [7:0] val;
    int         due;
    int         addr;
  } exp_t;
  exp_t sb[$];

  logic       watch = 1'b0;
  logic       stale_seen = 1'b0;
  logic [7:0] forbidden = 8'h00;

  nvram_upload #(
    .INDEX(8'd4), .ADDR_W(10), .SIZE(SZ), .READ_LAT(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .busy(busy), .ram_pause(ram_pause), .ram_ack(ram_ack),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // RAM model: data for a strobe appears RL edges after the strobe is sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd) begin
      pipe[0]  <= mem[ram_addr];
      rd_count <= rd_count + 1;
    end
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_data = pipe[RL-1];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] expect_byte(input logic [24:0] a);
    logic [9:0] idx;
    idx = a[9:0];
    return (a < 25'(SZ)) ? mem[idx] : 8'hFF;
  endfunction

  // Monitor: compares each expected byte on the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      checkOutput($sformatf("byte_addr_%0d", e.addr), ioctl_din, e.val);
    end
    if (watch && ioctl_din == forbidden) stale_seen <= 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [24:0] a, input bit keep);
    exp_t e;
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    e.val  = expect_byte(a);
    e.due  = cyc + RL + 2;
    e.addr = int'(a);
    tick(1);
    ioctl_rd = 1'b0;
    if (keep) sb.push_back(e);
    if (a < 25'(SZ)) exp_rd++;
  endtask

  task automatic startUpload();
    exp_t e;
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    tick(1);
    checkOutput("pause_rise", ram_pause, 1);
    checkOutput("busy_before_ack", busy, 0);
    tick(2);
    ram_ack = 1'b1;
    e.val  = mem[0];
    e.due  = cyc + RL + 2;
    e.addr = 0;
    sb.push_back(e);
    exp_rd++;
    tick(1);
    checkOutput("busy_grant", busy, 1);
    checkOutput("rd_after_ack", ram_rd, 1);
    tick(RL + 2);
  endtask

  task automatic endUpload();
    ioctl_upload = 1'b0;
    for (int i = 0; i < 5 && ram_pause; i++) tick(1);
    checkOutput("pause_release", ram_pause, 0);
    ram_ack = 1'b0;
    tick(2);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_din"}, ioctl_din, 8'h00);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_pause"}, ram_pause, 0);
    checkOutput({tag, "_rd"}, ram_rd, 0);
    checkOutput({tag, "_addr"}, ram_addr, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int rd_before;
    bit seen_pause, seen_busy, seen_rd;

    for (int i = 0; i < SZ; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[5] = 8'h5A; mem[7] = 8'hA7;
    for (int i = 0; i < RL; i++) pipe[i] = 8'h00;

    tick(3);
    checkResetOutputs("reset");
    reset_n = 1'b1;
    tick(1);

    $display("[TB] basic upload");
    startUpload();
    for (int a = 1; a <= 3; a++) begin
      applyStimulus(25'(a), 1'b1);
      tick(RL + 2);
    end

    $display("[TB] top of RAM and out of range");
    applyStimulus(25'd1023, 1'b1);
    tick(RL + 2);
    rd_before = rd_count;
    applyStimulus(25'd1024, 1'b1);
    tick(RL + 2);
    checkOutput("oob_no_ram_rd", rd_count, rd_before);

    $display("[TB] superseded request");
    forbidden = mem[5];
    watch = 1'b1;
    applyStimulus(25'd5, 1'b0);
    applyStimulus(25'd7, 1'b1);
    tick(RL + 6);
    watch = 1'b0;
    checkOutput("stale_byte_seen", stale_seen, 0);

    $display("[TB] random strobes");
    for (int k = 0; k < 24; k++) begin
      applyStimulus(25'($urandom_range(0, 1100)), 1'b1);
      tick(RL + 2 + int'($urandom_range(0, 3)));
    end

    $display("[TB] ram_ack lost while busy");
    ram_ack = 1'b0;
    tick(1);
    checkOutput("ackdrop_din", ioctl_din, 8'hFF);
    checkOutput("ackdrop_pause", ram_pause, 0);
    checkOutput("ackdrop_busy", busy, 0);
    tick(4);
    checkOutput("ackdrop_no_rearm", ram_pause, 0);
    endUpload();

    $display("[TB] foreign index");
    seen_pause = 0; seen_busy = 0; seen_rd = 0;
    ioctl_index  = 8'd0;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen_pause |= ram_pause;
      seen_busy  |= busy;
      seen_rd    |= ram_rd;
    end
    checkOutput("idx0_pause", seen_pause, 0);
    checkOutput("idx0_busy", seen_busy, 0);
    checkOutput("idx0_rd", seen_rd, 0);
    ioctl_upload = 1'b0;
    tick(2);

    $display("[TB] upload dropped mid-fetch");
    startUpload();
    applyStimulus(25'd9, 1'b0);
    ioctl_upload = 1'b0;
    tick(2);
    checkOutput("drop_pause", ram_pause, 0);
    checkOutput("drop_busy", busy, 0);
    ram_ack = 1'b0;
    tick(1);
    checkOutput("drop_idle_din", ioctl_din, 8'h00);
    tick(2);

    $display("[TB] reset while READY");
    startUpload();
    applyStimulus(25'd2, 1'b1);
    tick(RL + 2);
    reset_n = 1'b0;
    tick(1);
    checkResetOutputs("midreset");
    ioctl_upload = 1'b0;
    ram_ack = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    startUpload();
    applyStimulus(25'd3, 1'b1);
    tick(RL + 2);
    endUpload();

    tick(RL + 4);
    checkOutput("scoreboard_drained", sb.size(), 0);
    checkOutput("ram_rd_count", rd_count, exp_rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
